// File: rtl/mw_timer_ctrl.sv
// ============================================================================
// Module      : mw_timer_ctrl
// Description : Microwave cook timer. Handles BCD MM:SS keypad entry, the
//               start/pause/resume/clear sequencing and the 1 Hz countdown.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mw_timer_ctrl #(
  parameter int TICK_DIV = 100,
  parameter int PRE_W    = 7
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       stop,
  input  logic       door_open,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       mag_on,
  output logic       done,
  output logic [1:0] state
);

  localparam logic [1:0]       c_ST_IDLE  = 2'b00;
  localparam logic [1:0]       c_ST_RUN   = 2'b01;
  localparam logic [1:0]       c_ST_PAUSE = 2'b10;
  localparam logic [PRE_W-1:0] c_PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [1:0]       r_state;
  logic [PRE_W-1:0] r_pre;
  logic [3:0]       r_sec_ones;
  logic [3:0]       r_sec_tens;
  logic [3:0]       r_min_ones;
  logic [3:0]       r_min_tens;
  logic             r_mag_on;
  logic             r_done;

  logic [3:0] w_dec_so;
  logic [3:0] w_dec_st;
  logic [3:0] w_dec_mo;
  logic [3:0] w_dec_mt;
  logic       w_tick;
  logic       w_zero;
  logic       w_dec_zero;
  logic       w_key_ok;

  assign w_tick     = (r_pre == c_PRE_LAST);
  assign w_zero     = (r_sec_ones == 4'd0) && (r_sec_tens == 4'd0) &&
                      (r_min_ones == 4'd0) && (r_min_tens == 4'd0);
  assign w_dec_zero = (w_dec_so == 4'd0) && (w_dec_st == 4'd0) &&
                      (w_dec_mo == 4'd0) && (w_dec_mt == 4'd0);
  // A seconds-units digit above 5 would shift into an illegal seconds-tens.
  assign w_key_ok   = key_valid && (key_digit <= 4'd9) && (r_sec_ones <= 4'd5);

  // One-second decrement through the mod-10 / mod-6 / mod-10 borrow chain.
  always_comb begin
    w_dec_so = r_sec_ones;
    w_dec_st = r_sec_tens;
    w_dec_mo = r_min_ones;
    w_dec_mt = r_min_tens;
    if (r_sec_ones != 4'd0) begin
      w_dec_so = r_sec_ones - 4'd1;
    end else begin
      w_dec_so = 4'd9;
      if (r_sec_tens != 4'd0) begin
        w_dec_st = r_sec_tens - 4'd1;
      end else begin
        w_dec_st = 4'd5;
        if (r_min_ones != 4'd0) begin
          w_dec_mo = r_min_ones - 4'd1;
        end else begin
          w_dec_mo = 4'd9;
          w_dec_mt = r_min_tens - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state    <= c_ST_IDLE;
      r_pre      <= '0;
      r_sec_ones <= 4'd0;
      r_sec_tens <= 4'd0;
      r_min_ones <= 4'd0;
      r_min_tens <= 4'd0;
      r_mag_on   <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_ST_IDLE: begin
          r_mag_on <= 1'b0;
          if (stop) begin
            r_sec_ones <= 4'd0;
            r_sec_tens <= 4'd0;
            r_min_ones <= 4'd0;
            r_min_tens <= 4'd0;
          end else if (start && !door_open && !w_zero) begin
            r_state  <= c_ST_RUN;
            r_pre    <= '0;
            r_mag_on <= 1'b1;
          end else if (w_key_ok) begin
            r_min_tens <= r_min_ones;
            r_min_ones <= r_sec_tens;
            r_sec_tens <= r_sec_ones;
            r_sec_ones <= key_digit;
          end
        end

        c_ST_RUN: begin
          // Pause wins over a coincident tick, so the prescaler is simply held.
          if (door_open || stop) begin
            r_state  <= c_ST_PAUSE;
            r_mag_on <= 1'b0;
          end else if (w_tick) begin
            r_pre      <= '0;
            r_sec_ones <= w_dec_so;
            r_sec_tens <= w_dec_st;
            r_min_ones <= w_dec_mo;
            r_min_tens <= w_dec_mt;
            if (w_dec_zero) begin
              r_state  <= c_ST_IDLE;
              r_mag_on <= 1'b0;
              r_done   <= 1'b1;
            end
          end else begin
            r_pre <= r_pre + 1'b1;
          end
        end

        c_ST_PAUSE: begin
          r_mag_on <= 1'b0;
          if (stop) begin
            r_state    <= c_ST_IDLE;
            r_sec_ones <= 4'd0;
            r_sec_tens <= 4'd0;
            r_min_ones <= 4'd0;
            r_min_tens <= 4'd0;
          end else if (start && !door_open) begin
            r_state  <= c_ST_RUN;
            r_mag_on <= 1'b1;
          end
        end

        default: begin
          r_state  <= c_ST_IDLE;
          r_mag_on <= 1'b0;
        end
      endcase
    end
  end

  assign sec_ones = r_sec_ones;
  assign sec_tens = r_sec_tens;
  assign min_ones = r_min_ones;
  assign min_tens = r_min_tens;
  assign mag_on   = r_mag_on;
  assign done     = r_done;
  assign state    = r_state;

endmodule

`default_nettype wire

// File: tb/tb_mw_timer_ctrl.sv
// ============================================================================
// Module      : tb_mw_timer_ctrl
// Description : Self-checking bench for the microwave cook timer (TICK_DIV=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mw_timer_ctrl;

  localparam int TICK_DIV = 4;
  localparam int PRE_W    = 3;

  logic       clk = 1'b0;
  logic       clr;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       start;
  logic       stop;
  logic       door_open;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min_ones;
  logic [3:0] min_tens;
  logic       mag_on;
  logic       done;
  logic [1:0] state;

  int n_checks = 0;
  int n_pass   = 0;

  mw_timer_ctrl #(.TICK_DIV(TICK_DIV), .PRE_W(PRE_W)) dut (
    .clk      (clk),
    .clr      (clr),
    .key_valid(key_valid),
    .key_digit(key_digit),
    .start    (start),
    .stop     (stop),
    .door_open(door_open),
    .sec_ones (sec_ones),
    .sec_tens (sec_tens),
    .min_ones (min_ones),
    .min_tens (min_tens),
    .mag_on   (mag_on),
    .done     (done),
    .state    (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        clr;
    logic        kv;
    logic [3:0]  kd;
    logic        start;
    logic        stop;
    logic        door;
    logic [15:0] t;      // expected MM:SS as BCD nibbles
    logic [1:0]  st;
    logic        mag;
    logic        dn;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic expect_out(input string name, input logic [15:0] t, input logic [1:0] st,
                            input logic mag, input logic dn);
    check(name, {12'd0, min_tens, min_ones, sec_tens, sec_ones, state, mag_on, done},
                {12'd0, t, st, mag, dn});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clr = 1'b0; key_valid = 1'b0; key_digit = 4'd0;
    start = 1'b0; stop = 1'b0; door_open = 1'b0;
  endtask

  task automatic press_key(input logic [3:0] d);
    key_valid = 1'b1; key_digit = d;
    step();
    key_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1; step(); clr = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; step(); stop = 1'b0;
  endtask

  initial begin
    int bad;
    //            clr kv kd    st sp dr  time      state mag done
    vecs[0]  = '{1'b1,1'b0,4'd0, 1'b0,1'b0,1'b0,16'h0000,2'b00,1'b0,1'b0};
    vecs[1]  = '{1'b0,1'b1,4'd1, 1'b0,1'b0,1'b0,16'h0001,2'b00,1'b0,1'b0};
    vecs[2]  = '{1'b0,1'b1,4'd3, 1'b0,1'b0,1'b0,16'h0013,2'b00,1'b0,1'b0};
    vecs[3]  = '{1'b0,1'b1,4'd0, 1'b0,1'b0,1'b0,16'h0130,2'b00,1'b0,1'b0};
    vecs[4]  = '{1'b0,1'b1,4'd7, 1'b0,1'b0,1'b0,16'h1307,2'b00,1'b0,1'b0};
    vecs[5]  = '{1'b0,1'b1,4'd6, 1'b0,1'b0,1'b0,16'h1307,2'b00,1'b0,1'b0};
    vecs[6]  = '{1'b0,1'b1,4'd10,1'b0,1'b0,1'b0,16'h1307,2'b00,1'b0,1'b0};
    vecs[7]  = '{1'b0,1'b0,4'd0, 1'b0,1'b1,1'b0,16'h0000,2'b00,1'b0,1'b0};
    vecs[8]  = '{1'b0,1'b1,4'd10,1'b0,1'b0,1'b0,16'h0000,2'b00,1'b0,1'b0};
    vecs[9]  = '{1'b0,1'b0,4'd0, 1'b1,1'b0,1'b0,16'h0000,2'b00,1'b0,1'b0};
    vecs[10] = '{1'b0,1'b1,4'd5, 1'b0,1'b0,1'b0,16'h0005,2'b00,1'b0,1'b0};
    vecs[11] = '{1'b0,1'b0,4'd0, 1'b1,1'b0,1'b1,16'h0005,2'b00,1'b0,1'b0};
    vecs[12] = '{1'b0,1'b1,4'd9, 1'b0,1'b0,1'b0,16'h0059,2'b00,1'b0,1'b0};
    vecs[13] = '{1'b0,1'b1,4'd9, 1'b0,1'b0,1'b0,16'h0059,2'b00,1'b0,1'b0};
    vecs[14] = '{1'b1,1'b0,4'd0, 1'b0,1'b0,1'b0,16'h0000,2'b00,1'b0,1'b0};

    idle_inputs();
    clr = 1'b1;
    step();

    // Entry, rejection and ignored-start vectors
    for (int i = 0; i < 15; i++) begin
      clr = vecs[i].clr; key_valid = vecs[i].kv; key_digit = vecs[i].kd;
      start = vecs[i].start; stop = vecs[i].stop; door_open = vecs[i].door;
      step();
      idle_inputs();
      expect_out($sformatf("vec%0d", i), vecs[i].t, vecs[i].st, vecs[i].mag, vecs[i].dn);
    end

    // Countdown from 01:00 with seconds-tens borrow into minutes
    pulse_clr();
    press_key(4'd1); press_key(4'd0); press_key(4'd0);
    expect_out("set_0100", 16'h0100, 2'b00, 1'b0, 1'b0);
    pulse_start();
    expect_out("run_entry", 16'h0100, 2'b01, 1'b1, 1'b0);
    step(); step(); step();
    expect_out("pre_first_tick", 16'h0100, 2'b01, 1'b1, 1'b0);
    step();
    expect_out("first_tick", 16'h0059, 2'b01, 1'b1, 1'b0);
    bad = 0;
    for (int i = 5; i < 240; i++) begin
      step();
      if (done !== 1'b0 || state !== 2'b01) bad++;
    end
    check("no_early_done", 32'(bad), 32'd0);
    expect_out("last_second", 16'h0001, 2'b01, 1'b1, 1'b0);
    step();
    expect_out("complete", 16'h0000, 2'b00, 1'b0, 1'b1);
    step();
    expect_out("done_one_cycle", 16'h0000, 2'b00, 1'b0, 1'b0);

    // Door pause mid-period, resume from held prescaler
    pulse_clr();
    press_key(4'd6);
    pulse_start();
    step(); step(); step(); step();
    expect_out("door_pre_tick", 16'h0005, 2'b01, 1'b1, 1'b0);
    step(); step();
    door_open = 1'b1;
    step();
    expect_out("door_pause", 16'h0005, 2'b10, 1'b0, 1'b0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h0005 || state !== 2'b10 || mag_on !== 1'b0)
        bad++;
    end
    check("door_frozen", 32'(bad), 32'd0);
    door_open = 1'b0;
    pulse_start();
    expect_out("resume", 16'h0005, 2'b01, 1'b1, 1'b0);
    step();
    expect_out("resume_no_tick", 16'h0005, 2'b01, 1'b1, 1'b0);
    step();
    expect_out("resume_tick", 16'h0004, 2'b01, 1'b1, 1'b0);

    // Stop pauses, second stop clears
    pulse_stop();
    expect_out("stop_pause", 16'h0004, 2'b10, 1'b0, 1'b0);
    pulse_stop();
    expect_out("stop_clear", 16'h0000, 2'b00, 1'b0, 1'b0);

    // Minutes-tens borrow, door coincident with tick, reset mid-run
    pulse_clr();
    press_key(4'd1); press_key(4'd0); press_key(4'd0); press_key(4'd0);
    pulse_start();
    expect_out("run_1000", 16'h1000, 2'b01, 1'b1, 1'b0);
    step(); step(); step(); step();
    expect_out("borrow_0959", 16'h0959, 2'b01, 1'b1, 1'b0);
    step(); step(); step();
    door_open = 1'b1;
    step();
    door_open = 1'b0;
    expect_out("tick_suppressed", 16'h0959, 2'b10, 1'b0, 1'b0);
    pulse_start();
    expect_out("resume_at_tick", 16'h0959, 2'b01, 1'b1, 1'b0);
    pulse_clr();
    expect_out("clr_mid_run", 16'h0000, 2'b00, 1'b0, 1'b0);
    pulse_start();
    expect_out("start_after_clr", 16'h0000, 2'b00, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
